// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// Merges never-stalled ALU writebacks with variable-latency load returns into a
// single registered RegWrite/WriteReg/WriteData stream. Load returns that lose
// arbitration wait in a small in-order buffer. A younger ALU write to the same
// register cancels older buffered loads (WAW kill). busy_vec reports which
// registers still have a live buffered write.
module wb_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    input  logic [4:0]    alu_reg,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [4:0]    mem_reg,
    input  logic [DW-1:0] mem_data,
    output logic          RegWrite,
    output logic [4:0]    WriteReg,
    output logic [DW-1:0] WriteData,
    output logic [31:0]   busy_vec
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    // Load-return buffer: payload arrays plus a per-entry live bit.
    logic [4:0]       fifo_reg  [DEPTH];
    logic [DW-1:0]    fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_valid;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      count;

    logic          fifo_empty;
    logic          alu_issue;
    logic          mem_acc;
    logic          mem_live;
    logic          pop;
    logic          push;
    logic          issue;
    logic [4:0]    issue_reg;
    logic [DW-1:0] issue_data;

    // Ready depends only on registered occupancy, never on this cycle's inputs.
    assign mem_ready  = (count != CNT_FULL);
    assign fifo_empty = (count == '0);
    assign alu_issue  = alu_valid && (alu_reg != 5'd0);
    assign mem_acc    = mem_valid && mem_ready;
    // An accepted load survives unless it targets r0 or a same-cycle ALU write
    // to the same register supersedes it.
    assign mem_live   = mem_acc && (mem_reg != 5'd0) &&
                        !(alu_issue && (mem_reg == alu_reg));

    // Select at most one write per cycle: ALU, then buffer head, then bypass.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        pop        = 1'b0;
        push       = 1'b0;
        issue      = 1'b0;
        issue_reg  = alu_reg;
        issue_data = alu_data;
        if (alu_issue) begin
            issue = 1'b1;
            push  = mem_live;
        end else if (!fifo_empty) begin
            // A killed head is still popped, costing one idle output cycle.
            pop        = 1'b1;
            issue      = fifo_valid[head];
            issue_reg  = fifo_reg[head];
            issue_data = fifo_data[head];
            push       = mem_live;
        end else if (mem_live) begin
            issue      = 1'b1;
            issue_reg  = mem_reg;
            issue_data = mem_data;
        end
    end

    // Buffer control: pointers, occupancy and per-entry live bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            fifo_valid <= '0;
        end else begin
            if (alu_issue) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (fifo_reg[i] == alu_reg) fifo_valid[i] <= 1'b0;
                end
            end
            if (pop) begin
                fifo_valid[head] <= 1'b0;
                head             <= head + 1'b1;
            end
            if (push) begin
                fifo_valid[tail] <= 1'b1;
                tail             <= tail + 1'b1;
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Buffer payload storage, written on push only.
    always_ff @(posedge clk) begin
        // NOTE: payload arrays are not reset; the reset live bits guarantee no
        // stale entry is ever issued or reported busy.
        if (push) begin
            fifo_reg[tail]  <= mem_reg;
            fifo_data[tail] <= mem_data;
        end
    end

    // Registered write port; address and data hold when no write issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= issue;
            if (issue) begin
                WriteReg  <= issue_reg;
                WriteData <= issue_data;
            end
        end
    end

    // Hazard report: OR of destination registers over live buffered entries.
    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]) busy_vec[fifo_reg[i]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DW    = 32;

    logic          clk;
    logic          rst_n;
    logic          alu_valid;
    logic [4:0]    alu_reg;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_reg;
    logic [DW-1:0] mem_data;
    logic          RegWrite;
    logic [4:0]    WriteReg;
    logic [DW-1:0] WriteData;
    logic [31:0]   busy_vec;

    wb_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_reg   (mem_reg),
        .mem_data  (mem_data),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program-ordered list of pending load writes.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        q[$];
    bit          m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    function automatic void model_reset();
        q.delete();
        m_rw = 1'b0;
        m_wr = '0;
        m_wd = '0;
    endfunction

    function automatic void model_cycle(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                                        input bit mv, input logic [4:0] mr, input logic [31:0] md);
        bit   accepted;
        bit   alu_w;
        bit   mem_w;
        ent_t e;
        accepted = mv && (q.size() != DEPTH);
        alu_w    = av && (ar != 0);
        // A younger ALU write makes older pending loads to that register dead.
        if (alu_w) foreach (q[i]) if (q[i].r == ar) q[i].live = 1'b0;
        mem_w = accepted && (mr != 0) && !(alu_w && mr == ar);
        m_rw  = 1'b0;
        if (alu_w) begin
            m_rw = 1'b1; m_wr = ar; m_wd = ad;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            if (e.live) begin
                m_rw = 1'b1; m_wr = e.r; m_wd = e.d;
            end
        end else if (mem_w) begin
            m_rw = 1'b1; m_wr = mr; m_wd = md; mem_w = 1'b0;
        end
        if (mem_w) begin
            e.r = mr; e.d = md; e.live = 1'b1;
            q.push_back(e);
        end
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        foreach (q[i]) if (q[i].live) b[q[i].r] = 1'b1;
        return b;
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".regwrite"},  {31'd0, RegWrite}, {31'd0, m_rw});
        check({tag, ".writereg"},  {27'd0, WriteReg}, {27'd0, m_wr});
        check({tag, ".writedata"}, WriteData, m_wd);
        check({tag, ".mem_ready"}, {31'd0, mem_ready}, {31'd0, (q.size() != DEPTH)});
        check({tag, ".busy_vec"},  busy_vec, model_busy());
    endtask

    // One clock: drive inputs away from the edge, clock, then compare.
    task automatic step(input string tag,
                        input bit av, input logic [4:0] ar, input logic [31:0] ad,
                        input bit mv, input logic [4:0] mr, input logic [31:0] md);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        @(posedge clk);
        #1;
        model_cycle(av, ar, ad, mv, mr, md);
        compare_model(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        bit          av;
        logic [4:0]  ar;
        logic [31:0] ad;
        bit          mv;
        logic [4:0]  mr;
        logic [31:0] md;
        bit          rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        bit          rdy;
        logic [31:0] busy;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Saturation table: ALU r1..r6 while loads r9..r14 are offered.
        tbl[0]  = '{1'b1, 5'd1, 32'h101, 1'b1, 5'd9,  32'h909, 1'b1, 5'd1,  32'h101, 1'b1, 32'h0000_0200};
        tbl[1]  = '{1'b1, 5'd2, 32'h102, 1'b1, 5'd10, 32'h90A, 1'b1, 5'd2,  32'h102, 1'b1, 32'h0000_0600};
        tbl[2]  = '{1'b1, 5'd3, 32'h103, 1'b1, 5'd11, 32'h90B, 1'b1, 5'd3,  32'h103, 1'b1, 32'h0000_0E00};
        tbl[3]  = '{1'b1, 5'd4, 32'h104, 1'b1, 5'd12, 32'h90C, 1'b1, 5'd4,  32'h104, 1'b0, 32'h0000_1E00};
        tbl[4]  = '{1'b1, 5'd5, 32'h105, 1'b1, 5'd13, 32'h90D, 1'b1, 5'd5,  32'h105, 1'b0, 32'h0000_1E00};
        tbl[5]  = '{1'b1, 5'd6, 32'h106, 1'b1, 5'd14, 32'h90E, 1'b1, 5'd6,  32'h106, 1'b0, 32'h0000_1E00};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,   1'b1, 5'd13, 32'h90D, 1'b1, 5'd9,  32'h909, 1'b1, 32'h0000_1C00};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,   1'b1, 5'd13, 32'h90D, 1'b1, 5'd10, 32'h90A, 1'b1, 32'h0000_3800};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,   1'b1, 5'd14, 32'h90E, 1'b1, 5'd11, 32'h90B, 1'b1, 32'h0000_7000};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   1'b1, 5'd12, 32'h90C, 1'b1, 32'h0000_6000};
        tbl[10] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   1'b1, 5'd13, 32'h90D, 1'b1, 32'h0000_4000};
        tbl[11] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   1'b1, 5'd14, 32'h90E, 1'b1, 32'h0000_0000};
        tbl[12] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   1'b0, 5'd14, 32'h90E, 1'b1, 32'h0000_0000};

        rst_n = 1'b0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        model_reset();

        // Reset state, then idle.
        #1;
        check("reset.regwrite",  {31'd0, RegWrite}, 32'd0);
        check("reset.writereg",  {27'd0, WriteReg}, 32'd0);
        check("reset.writedata", WriteData, 32'd0);
        check("reset.mem_ready", {31'd0, mem_ready}, 32'd1);
        check("reset.busy_vec",  busy_vec, 32'd0);
        #20 rst_n = 1'b1;
        idle("idle0");
        idle("idle1");

        // Bypass of a load into an empty buffer.
        step("bypass", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5_A5A5);
        check("bypass.regwrite",  {31'd0, RegWrite}, 32'd1);
        check("bypass.writereg",  {27'd0, WriteReg}, 32'd5);
        check("bypass.writedata", WriteData, 32'hA5A5_A5A5);
        check("bypass.busy_vec",  busy_vec, 32'd0);
        idle("bypass_hold");
        check("hold.writedata", WriteData, 32'hA5A5_A5A5);

        // Saturation table from a clean reset.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            step(tag, tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].mv, tbl[i].mr, tbl[i].md);
            check({tag, ".rw_tbl"},   {31'd0, RegWrite},  {31'd0, tbl[i].rw});
            check({tag, ".wr_tbl"},   {27'd0, WriteReg},  {27'd0, tbl[i].wr});
            check({tag, ".wd_tbl"},   WriteData, tbl[i].wd);
            check({tag, ".rdy_tbl"},  {31'd0, mem_ready}, {31'd0, tbl[i].rdy});
            check({tag, ".busy_tbl"}, busy_vec, tbl[i].busy);
        end

        // WAW kill of a buffered load; killed head costs one idle cycle.
        step("waw_a", 1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h11);
        check("waw_a.busy7", busy_vec, 32'h0000_0080);
        step("waw_b", 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
        check("waw_b.writedata", WriteData, 32'h22);
        check("waw_b.busy_vec", busy_vec, 32'd0);
        idle("waw_c");
        check("waw_c.regwrite", {31'd0, RegWrite}, 32'd0);
        idle("waw_d");

        // Same-cycle ALU and load to the same register.
        step("same_a", 1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2);
        check("same_a.writedata", WriteData, 32'h1);
        idle("same_b");
        check("same_b.regwrite", {31'd0, RegWrite}, 32'd0);

        // Load to r0 is accepted but never written.
        step("r0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        check("r0.regwrite", {31'd0, RegWrite}, 32'd0);

        // Reset with three buffered entries discards them.
        step("fill1", 1'b1, 5'd1, 32'h31, 1'b1, 5'd20, 32'h20);
        step("fill2", 1'b1, 5'd2, 32'h32, 1'b1, 5'd21, 32'h21);
        step("fill3", 1'b1, 5'd3, 32'h33, 1'b1, 5'd22, 32'h22);
        check("fill3.busy_vec", busy_vec, 32'h0070_0000);
        alu_valid = 1'b0; mem_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst.regwrite",  {31'd0, RegWrite}, 32'd0);
        check("midrst.busy_vec",  busy_vec, 32'd0);
        check("midrst.mem_ready", {31'd0, mem_ready}, 32'd1);
        model_reset();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle($sformatf("post_rst%0d", i));

        // Randomized traffic on a narrow register range to provoke kills.
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i),
                 ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom(),
                 ($urandom_range(0, 99) < 70), 5'($urandom_range(0, 7)), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
